// File: rtl/tftlcd_pkg.sv
// Shared definitions for the TFT-LCD 8080-style bus engine: FSM state
// encodings, Avalon register offsets, status bit positions and the
// command entry layout shared between the engine and its command FIFO.
package tftlcd_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETUP  = 2'd1;
    localparam state_t ST_STROBE = 2'd2;
    localparam state_t ST_HOLD   = 2'd3;

    // Avalon word offsets
    localparam logic [1:0] REG_DATA   = 2'd0;  // W: data write (rs=1), R: read data
    localparam logic [1:0] REG_CMD    = 2'd1;  // W: command write (rs=0)
    localparam logic [1:0] REG_STATUS = 2'd2;  // W: queue a panel read, R: status
    localparam logic [1:0] REG_CTRL   = 2'd3;  // W: bit0 clears overflow

    // Status word bit positions
    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_RD_VALID  = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_LEVEL_LSB = 4;

    localparam int ENTRY_W = 18;
    localparam int CNT_W   = 8;

    typedef struct packed {
        logic        rd;
        logic        rs;
        logic [15:0] data;
    } entry_t;

    // Phase length for the current entry, chosen by transfer direction.
    function automatic logic [CNT_W-1:0] phase_len(input logic rd, input int rd_cycles,
                                                   input int wr_cycles);
        return rd ? CNT_W'(rd_cycles) : CNT_W'(wr_cycles);
    endfunction

endpackage

// File: rtl/tftlcd_cmd_fifo.sv
// Command FIFO for the bus engine. Head entry is visible combinationally
// so the engine can pop straight into its entry register; the storage is
// small enough to live in fabric registers. Pushes while full and pops
// while empty are ignored; full/empty come from the pre-edge level.
module tftlcd_cmd_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 18
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic [WIDTH-1:0]                  push_data,
    input  logic                              pop,
    output logic [WIDTH-1:0]                  pop_data,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [WIDTH-1:0] slot_q [FIFO_DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level_reg == LVL_W'(FIFO_DEPTH));
    assign empty    = (level_reg == '0);
    assign level    = level_reg;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = slot_q[rd_ptr_reg];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // One storage register per slot, loaded when the write pointer selects it
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            logic [WIDTH-1:0] slot_reg;
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi)))
                    slot_reg <= push_data;
            end
            assign slot_q[gi] = slot_reg;
        end
    endgenerate

    // Pointer and occupancy bookkeeping; simultaneous push+pop keeps level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_ok)
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (push_ok && !pop_ok)
                level_reg <= level_reg + LVL_W'(1);
            else if (pop_ok && !push_ok)
                level_reg <= level_reg - LVL_W'(1);
        end
    end

endmodule

// File: rtl/tftlcd_bus_engine.sv
// Avalon-MM slave that queues panel commands/data and plays them out on an
// 8080-style TFT-LCD bus (cs_n/rs/wr_n/rd_n with a shared 16-bit data bus).
// Panel pins are registered from the FSM state, so each phase appears on
// the pins one clock after the FSM enters it and never glitches.
module tftlcd_bus_engine
    import tftlcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int WR_LOW     = 2,
    parameter int WR_HIGH    = 2,
    parameter int RD_LOW     = 4,
    parameter int RD_HIGH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [15:0] lcd_data_out,
    output logic        lcd_data_oe,
    input  logic [15:0] lcd_data_in
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic             wr_sel;
    logic             push;
    entry_t           push_entry;
    logic             pop;
    logic [17:0]      head_bits;
    entry_t           head_entry;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level;
    logic [3:0]       level_nib;
    logic             clr_ovf;
    logic             rd_clear;
    logic             capture;
    logic             busy;
    logic [31:0]      status;
    logic             unused_bits;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    entry_t           entry_reg, entry_next;
    logic [15:0]      rd_data_reg;
    logic             rd_valid_reg;
    logic             overflow_reg;
    logic [31:0]      readdata_reg;
    logic             cs_n_reg, rs_reg, wr_n_reg, rd_n_reg, oe_reg;
    logic [15:0]      dout_reg;

    assign unused_bits = ^writedata[31:16];
    assign wr_sel      = chipselect && !write_n;
    assign clr_ovf     = wr_sel && (address == REG_CTRL) && writedata[0];
    assign rd_clear    = chipselect && !read_n && (address == REG_DATA);
    assign head_entry  = entry_t'(head_bits);
    assign busy        = (state_reg != ST_IDLE) || !empty;
    assign level_nib   = 4'(level);
    assign capture     = (state_reg == ST_STROBE) && (cnt_reg == CNT_W'(1)) && entry_reg.rd;

    // Decode Avalon writes into FIFO entries
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (wr_sel) begin
            case (address)
                REG_DATA: begin
                    push       = 1'b1;
                    push_entry = '{rd: 1'b0, rs: 1'b1, data: writedata[15:0]};
                end
                REG_CMD: begin
                    push       = 1'b1;
                    push_entry = '{rd: 1'b0, rs: 1'b0, data: writedata[15:0]};
                end
                REG_STATUS: begin
                    push       = 1'b1;
                    push_entry = '{rd: 1'b1, rs: writedata[0], data: 16'h0000};
                end
                default: ;
            endcase
        end
    end

    tftlcd_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (ENTRY_W)
    ) u_cmd_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .pop_data   (head_bits),
        .full       (full),
        .empty      (empty),
        .level      (level)
    );

    // Transfer sequencer: IDLE -> SETUP -> STROBE -> HOLD -> (SETUP | IDLE)
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        entry_next = entry_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    entry_next = head_entry;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_STROBE;
                cnt_next   = phase_len(entry_reg.rd, RD_LOW, WR_LOW);
            end
            ST_STROBE: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_HOLD;
                    cnt_next   = phase_len(entry_reg.rd, RD_HIGH, WR_HIGH);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_reg == CNT_W'(1)) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        entry_next = head_entry;
                        state_next = ST_SETUP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state, phase counter and current entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            entry_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            entry_reg <= entry_next;
        end
    end

    // Sticky flags and read capture; a set in the same cycle as a clear wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (capture) begin
                rd_data_reg  <= lcd_data_in;
                rd_valid_reg <= 1'b1;
            end else if (rd_clear) begin
                rd_valid_reg <= 1'b0;
            end
            if (push && full)
                overflow_reg <= 1'b1;
            else if (clr_ovf)
                overflow_reg <= 1'b0;
        end
    end

    // Status word assembly
    always_comb begin
        status                            = '0;
        status[STAT_BUSY]                 = busy;
        status[STAT_FULL]                 = full;
        status[STAT_RD_VALID]             = rd_valid_reg;
        status[STAT_OVERFLOW]             = overflow_reg;
        status[STAT_LEVEL_LSB +: 4]       = level_nib;
    end

    // Read mux registered every clock for a fixed one-cycle latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_reg <= '0;
        end else begin
            case (address)
                REG_DATA:   readdata_reg <= {16'h0000, rd_data_reg};
                REG_STATUS: readdata_reg <= status;
                default:    readdata_reg <= '0;
            endcase
        end
    end

    // Panel pin registers driven from the current FSM phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n_reg <= 1'b1;
            rs_reg   <= 1'b0;
            wr_n_reg <= 1'b1;
            rd_n_reg <= 1'b1;
            oe_reg   <= 1'b0;
            dout_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            cs_n_reg <= 1'b1;
            rs_reg   <= 1'b0;
            wr_n_reg <= 1'b1;
            rd_n_reg <= 1'b1;
            oe_reg   <= 1'b0;
            dout_reg <= '0;
        end else begin
            cs_n_reg <= 1'b0;
            rs_reg   <= entry_reg.rs;
            wr_n_reg <= !((state_reg == ST_STROBE) && !entry_reg.rd);
            rd_n_reg <= !((state_reg == ST_STROBE) && entry_reg.rd);
            oe_reg   <= !entry_reg.rd;
            dout_reg <= entry_reg.rd ? 16'h0000 : entry_reg.data;
        end
    end

    assign readdata     = readdata_reg;
    assign lcd_cs_n     = cs_n_reg;
    assign lcd_rs       = rs_reg;
    assign lcd_wr_n     = wr_n_reg;
    assign lcd_rd_n     = rd_n_reg;
    assign lcd_data_oe  = oe_reg;
    assign lcd_data_out = dout_reg;

endmodule

// File: tb/tb_tftlcd_bus_engine.sv
// Bench for tftlcd_bus_engine: Avalon stimulus tasks, a bus monitor that
// pops expected panel transfers from a scoreboard queue, and per-feature
// scenario tasks with inline comparisons.
module tb_tftlcd_bus_engine;

    localparam int WR_LOW  = 2;
    localparam int WR_HIGH = 2;
    localparam int RD_LOW  = 4;
    localparam int RD_HIGH = 2;

    typedef struct packed {
        logic        rd;
        logic        rs;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        lcd_cs_n;
    logic        lcd_rs;
    logic        lcd_wr_n;
    logic        lcd_rd_n;
    logic [15:0] lcd_data_out;
    logic        lcd_data_oe;
    logic [15:0] lcd_data_in;

    int   n_pass = 0;
    int   n_total = 0;
    int   strobe_count = 0;
    exp_t sb_q[$];

    tftlcd_bus_engine #(
        .FIFO_DEPTH (8),
        .WR_LOW     (WR_LOW),
        .WR_HIGH    (WR_HIGH),
        .RD_LOW     (RD_LOW),
        .RD_HIGH    (RD_HIGH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .read_n       (read_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .lcd_cs_n     (lcd_cs_n),
        .lcd_rs       (lcd_rs),
        .lcd_wr_n     (lcd_wr_n),
        .lcd_rd_n     (lcd_rd_n),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .lcd_data_in  (lcd_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: checks each strobe against the scoreboard and its width
    initial begin
        logic wr_prev, rd_prev, rd_oe_bad;
        int   wr_low, rd_low;
        exp_t cur;
        wr_prev = 1'b1; rd_prev = 1'b1; wr_low = 0; rd_low = 0; rd_oe_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wr_prev = 1'b1; rd_prev = 1'b1; wr_low = 0; rd_low = 0; rd_oe_bad = 1'b0;
            end else begin
                if (wr_prev && !lcd_wr_n) begin
                    strobe_count++;
                    n_total++;
                    $display("lcd write rs=%b data=%h cs_n=%b oe=%b", lcd_rs, lcd_data_out, lcd_cs_n, lcd_data_oe);
                    if (sb_q.size() == 0) begin
                        $display("FAIL wr_strobe: unexpected write strobe data=%h, want none", lcd_data_out);
                    end else begin
                        cur = sb_q.pop_front();
                        if (cur.rd !== 1'b0 || lcd_rs !== cur.rs || lcd_data_out !== cur.data ||
                            lcd_data_oe !== 1'b1 || lcd_cs_n !== 1'b0)
                            $display("FAIL wr_strobe: got rd=0 rs=%b data=%h oe=%b cs_n=%b, want rd=%b rs=%b data=%h oe=1 cs_n=0",
                                     lcd_rs, lcd_data_out, lcd_data_oe, lcd_cs_n, cur.rd, cur.rs, cur.data);
                        else
                            n_pass++;
                    end
                    wr_low = 1;
                end else if (!lcd_wr_n) begin
                    wr_low++;
                end
                if (!wr_prev && lcd_wr_n) begin
                    n_total++;
                    if (wr_low !== WR_LOW)
                        $display("FAIL wr_width: got %0d low cycles, want %0d", wr_low, WR_LOW);
                    else
                        n_pass++;
                end

                if (rd_prev && !lcd_rd_n) begin
                    strobe_count++;
                    n_total++;
                    $display("lcd read rs=%b cs_n=%b oe=%b", lcd_rs, lcd_cs_n, lcd_data_oe);
                    if (sb_q.size() == 0) begin
                        $display("FAIL rd_strobe: unexpected read strobe, want none");
                    end else begin
                        cur = sb_q.pop_front();
                        if (cur.rd !== 1'b1 || lcd_rs !== cur.rs || lcd_cs_n !== 1'b0)
                            $display("FAIL rd_strobe: got rd=1 rs=%b cs_n=%b, want rd=%b rs=%b cs_n=0",
                                     lcd_rs, lcd_cs_n, cur.rd, cur.rs);
                        else
                            n_pass++;
                    end
                    rd_low = 1;
                    rd_oe_bad = lcd_data_oe;
                end else if (!lcd_rd_n) begin
                    rd_low++;
                    if (lcd_data_oe) rd_oe_bad = 1'b1;
                end
                if (!rd_prev && lcd_rd_n) begin
                    n_total++;
                    if (rd_low !== RD_LOW || rd_oe_bad)
                        $display("FAIL rd_width: got %0d low cycles oe_seen=%b, want %0d and oe_seen=0",
                                 rd_low, rd_oe_bad, RD_LOW);
                    else
                        n_pass++;
                    rd_oe_bad = 1'b0;
                end
                wr_prev = lcd_wr_n;
                rd_prev = lcd_rd_n;
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = a; writedata = d;
        @(posedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b1; read_n = 1'b0; address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        bit done;
        done = 1'b0;
        s = '0;
        for (int i = 0; i < 200 && !done; i++) begin
            bus_read(2'd2, s);
            if (s[0] == 1'b0) done = 1'b1;
        end
        bus_idle();
        n_total++;
        if (!done) $display("FAIL %s_idle: busy=%b after 200 polls, want 0", tag, s[0]);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [31:0] s;
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        address = 2'd0; writedata = '0; lcd_data_in = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if (lcd_cs_n !== 1'b1 || lcd_wr_n !== 1'b1 || lcd_rd_n !== 1'b1 || lcd_rs !== 1'b0 ||
            lcd_data_oe !== 1'b0 || lcd_data_out !== 16'h0 || readdata !== 32'h0)
            $display("FAIL reset_outputs: got cs_n=%b wr_n=%b rd_n=%b rs=%b oe=%b dout=%h rdata=%h, want 1 1 1 0 0 0000 00000000",
                     lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_data_oe, lcd_data_out, readdata);
        else n_pass++;
        reset = 1'b0;
        bus_read(2'd2, s);
        n_total++;
        if (s !== 32'h0) $display("FAIL reset_status: got %h, want 00000000", s);
        else n_pass++;
        bus_read(2'd0, s);
        n_total++;
        if (s !== 32'h0) $display("FAIL reset_rddata: got %h, want 00000000", s);
        else n_pass++;
        bus_idle();
    endtask

    task automatic test_write_sequence();
        logic [31:0] s;
        bus_write(2'd1, 32'h0000_002C);
        sb_q.push_back('{rd: 1'b0, rs: 1'b0, data: 16'h002C});
        bus_write(2'd0, 32'h0000_F800);
        sb_q.push_back('{rd: 1'b0, rs: 1'b1, data: 16'hF800});
        bus_idle();
        n_total++;
        if (lcd_cs_n !== 1'b1) $display("FAIL cs_early: got cs_n=%b at t+1, want 1", lcd_cs_n);
        else n_pass++;
        for (int i = 2; i <= 11; i++) begin
            @(negedge clk);
            n_total++;
            if (lcd_cs_n !== 1'b0) $display("FAIL cs_held: got cs_n=%b at t+%0d, want 0", lcd_cs_n, i);
            else n_pass++;
            if (i == 2) begin
                n_total++;
                if (lcd_rs !== 1'b0 || lcd_wr_n !== 1'b1 || lcd_data_oe !== 1'b1 || lcd_data_out !== 16'h002C)
                    $display("FAIL setup1: got rs=%b wr_n=%b oe=%b dout=%h, want 0 1 1 002c",
                             lcd_rs, lcd_wr_n, lcd_data_oe, lcd_data_out);
                else n_pass++;
            end
            if (i == 3 || i == 4 || i == 8 || i == 9) begin
                n_total++;
                if (lcd_wr_n !== 1'b0) $display("FAIL strobe_low: got wr_n=%b at t+%0d, want 0", lcd_wr_n, i);
                else n_pass++;
            end
            if (i == 7) begin
                n_total++;
                if (lcd_rs !== 1'b1 || lcd_wr_n !== 1'b1 || lcd_data_out !== 16'hF800)
                    $display("FAIL setup2: got rs=%b wr_n=%b dout=%h, want 1 1 f800",
                             lcd_rs, lcd_wr_n, lcd_data_out);
                else n_pass++;
            end
        end
        @(negedge clk);
        n_total++;
        if (lcd_cs_n !== 1'b1 || lcd_data_oe !== 1'b0)
            $display("FAIL cs_release: got cs_n=%b oe=%b at t+12, want 1 0", lcd_cs_n, lcd_data_oe);
        else n_pass++;
        bus_read(2'd2, s);
        n_total++;
        if (s !== 32'h0) $display("FAIL write_done_status: got %h, want 00000000", s);
        else n_pass++;
        bus_idle();
    endtask

    task automatic test_overflow();
        logic [31:0] s;
        for (int i = 0; i < 10; i++) begin
            bus_write(2'd0, 32'hA000 + 32'(i));
            sb_q.push_back('{rd: 1'b0, rs: 1'b1, data: 16'(32'hA000 + 32'(i))});
        end
        bus_read(2'd2, s);
        n_total++;
        if (s !== 32'h0000_0083) $display("FAIL full_status: got %h, want 00000083", s);
        else n_pass++;
        bus_write(2'd0, 32'h0000_BEEF);   // lands on a pop while full: dropped
        bus_read(2'd2, s);
        n_total++;
        if (s !== 32'h0000_0079) $display("FAIL overflow_status: got %h, want 00000079", s);
        else n_pass++;
        bus_write(2'd3, 32'h0000_0001);
        bus_read(2'd2, s);
        n_total++;
        if (s !== 32'h0000_0071) $display("FAIL overflow_clear: got %h, want 00000071", s);
        else n_pass++;
        bus_idle();
        wait_idle("overflow");
    endtask

    task automatic test_push_pop_level();
        logic [31:0] s;
        for (int i = 0; i < 4; i++) begin
            bus_write(2'd1, 32'h0000_0C00 + 32'(i));
            sb_q.push_back('{rd: 1'b0, rs: 1'b0, data: 16'(32'h0C00 + 32'(i))});
        end
        bus_idle();
        @(negedge clk);
        bus_write(2'd1, 32'h0000_0C04);   // coincides with the HOLD pop at level 3
        sb_q.push_back('{rd: 1'b0, rs: 1'b0, data: 16'h0C04});
        bus_read(2'd2, s);
        n_total++;
        if (s !== 32'h0000_0031) $display("FAIL push_pop_level: got %h, want 00000031", s);
        else n_pass++;
        bus_idle();
        wait_idle("pushpop");
    endtask

    task automatic test_read();
        logic [31:0] s;
        lcd_data_in = 16'h9341;
        bus_write(2'd2, 32'h0000_0001);
        sb_q.push_back('{rd: 1'b1, rs: 1'b1, data: 16'h0000});
        bus_idle();
        wait_idle("read1");
        bus_read(2'd2, s);
        n_total++;
        if (s !== 32'h0000_0004) $display("FAIL rd_valid_set: got %h, want 00000004", s);
        else n_pass++;
        bus_read(2'd0, s);
        n_total++;
        if (s !== 32'h0000_9341) $display("FAIL rd_data: got %h, want 00009341", s);
        else n_pass++;
        bus_read(2'd2, s);
        n_total++;
        if (s !== 32'h0000_0000) $display("FAIL rd_valid_clear: got %h, want 00000000", s);
        else n_pass++;
        lcd_data_in = 16'h5A5A;
        bus_write(2'd2, 32'h0000_0000);
        sb_q.push_back('{rd: 1'b1, rs: 1'b0, data: 16'h0000});
        bus_idle();
        wait_idle("read2");
        bus_read(2'd0, s);
        n_total++;
        if (s !== 32'h0000_5A5A) $display("FAIL rd_overwrite: got %h, want 00005a5a", s);
        else n_pass++;
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        int snap;
        bit cs_bad;
        bus_write(2'd1, 32'h0000_1111);
        sb_q.push_back('{rd: 1'b0, rs: 1'b0, data: 16'h1111});
        bus_write(2'd0, 32'h0000_2222);
        sb_q.push_back('{rd: 1'b0, rs: 1'b1, data: 16'h2222});
        bus_write(2'd0, 32'h0000_3333);
        sb_q.push_back('{rd: 1'b0, rs: 1'b1, data: 16'h3333});
        bus_idle();
        @(negedge clk);
        n_total++;
        if (lcd_wr_n !== 1'b0) $display("FAIL mid_strobe: got wr_n=%b before reset, want 0", lcd_wr_n);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (lcd_cs_n !== 1'b1 || lcd_wr_n !== 1'b1 || lcd_rd_n !== 1'b1 || lcd_rs !== 1'b0 ||
            lcd_data_oe !== 1'b0 || lcd_data_out !== 16'h0 || readdata !== 32'h0)
            $display("FAIL async_reset: got cs_n=%b wr_n=%b rd_n=%b rs=%b oe=%b dout=%h rdata=%h, want 1 1 1 0 0 0000 00000000",
                     lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_data_oe, lcd_data_out, readdata);
        else n_pass++;
        sb_q.delete();
        snap = strobe_count;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cs_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (lcd_cs_n !== 1'b1 || lcd_wr_n !== 1'b1) cs_bad = 1'b1;
        end
        n_total++;
        if (cs_bad || strobe_count !== snap)
            $display("FAIL post_reset_quiet: got activity=%b strobes=%0d, want activity=0 strobes=%0d",
                     cs_bad, strobe_count, snap);
        else n_pass++;
        bus_read(2'd2, s);
        n_total++;
        if (s !== 32'h0) $display("FAIL post_reset_status: got %h, want 00000000", s);
        else n_pass++;
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_write_sequence();
        test_overflow();
        test_push_pop_level();
        test_read();
        test_reset_mid();
        n_total++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending transfers, want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tftlcd_bus_engine.md
TFTLCD_BUS_ENGINE -- requirements
Module: tftlcd_bus_engine

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The module SHALL expose these parameters:
- FIFO_DEPTH, default 8: number of command entries.
- WR_LOW, default 2: wr_n low cycles.
- WR_HIGH, default 2: post-strobe hold cycles for writes.
- RD_LOW, default 4: rd_n low cycles.
- RD_HIGH, default 2: post-strobe hold cycles for reads.
All timing parameters SHALL be >=1.
REQ-003 The module SHALL have these ports:
- clk  in  1  system clock.
- reset  in  1  async active-high reset.
- address  in  2  Avalon slave word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- lcd_cs_n  out  1  panel chip select.
- lcd_rs  out  1  register select (0=command, 1=data).
- lcd_wr_n  out  1  write strobe.
- lcd_rd_n  out  1  read strobe.
- lcd_data_out  out  16  bus drive value.
- lcd_data_oe  out  1  bus drive enable; the top-level tristate is built from it.
- lcd_data_in  in  16  sampled bus value.

Function
REQ-004 The register map SHALL be:
- 0 W: push a write entry {rd=0, rs=1, writedata[15:0]}.
- 0 R: return rd_data and clear rd_valid.
- 1 W: push a write entry {rd=0, rs=0, writedata[15:0]}.
- 1 R: return 0.
- 2 W: push a read entry {rd=1, rs=writedata[0], data=0}.
- 2 R: return status.
- 3 W: bit0=1 clears overflow.
- 3 R: return 0.
REQ-005 Status SHALL be {24'b0, level[3:0], overflow, rd_valid, full, busy}. busy = FSM not IDLE or FIFO non-empty.
REQ-006 readdata SHALL update on every clock from the mux of the current address, giving 1-cycle read latency; the rd_valid clear SHALL occur only when chipselect && ~read_n && address==0.
REQ-007 A push while the FIFO is full SHALL be dropped and SHALL set sticky overflow; full SHALL be evaluated on the pre-edge level, even when a pop occurs in the same cycle.
REQ-008 A simultaneous push and pop on a non-full FIFO SHALL leave level unchanged.
REQ-009 The FSM states SHALL be IDLE, SETUP, STROBE and HOLD.
REQ-010 In IDLE with the FIFO non-empty, the FSM SHALL pop into an entry register and go to SETUP. A push at edge t SHALL produce SETUP outputs from t+2.
REQ-011 SETUP SHALL last 1 cycle with cs_n=0, rs=entry.rs, wr_n=rd_n=1, and oe=~entry.rd.
REQ-012 STROBE SHALL hold wr_n=0 (write) or rd_n=0 (read) for WR_LOW or RD_LOW cycles, using a down-counter.
REQ-013 For a read, rd_data SHALL capture lcd_data_in on the last STROBE cycle, and rd_valid SHALL set. A new read SHALL overwrite rd_data. If the capture coincides with a status-clear read, the set SHALL win.
REQ-014 HOLD SHALL keep strobes high and cs_n=0 for WR_HIGH or RD_HIGH cycles. It SHALL then pop the next entry and go to SETUP if the FIFO is non-empty, with cs_n staying low; otherwise it SHALL go to IDLE with cs_n=1.
REQ-015 lcd_data_out SHALL equal entry.data whenever oe=1, and oe SHALL be 0 in IDLE and throughout read entries.

Reset
REQ-016 Reset SHALL immediately force:
- readdata=0, rd_data=0, rd_valid=0, overflow=0, level=0.
- state=IDLE.
- lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=0, lcd_data_oe=0, lcd_data_out=0.
REQ-017 A reset mid-transfer SHALL abort the entry and discard all FIFO contents; no strobe glitch low SHALL follow deassertion.

Structure
REQ-018 A shared package tftlcd_pkg SHALL hold the state enum, the register offsets, the status bit positions, and the 18-bit entry typedef {rd, rs, data[15:0]}.
REQ-019 The FIFO SHALL be a sub-module, tftlcd_cmd_fifo: synchronous, registered, with FIFO_DEPTH and width 18, and with push, pop, full, empty and level ports.

Verification
REQ-020 Write addr1=0x002C, then addr0=0xF800 -> first transfer: cs_n falls at t+2, rs=0, wr_n low 2 cycles, data 0x002C. Second transfer: rs=1, data 0xF800, cs_n held low between the two. Then cs_n=1 and busy=0.
REQ-021 9 writes back-to-back while the engine is stalled in its first transfer -> level reaches 8, the 9th write is dropped, overflow=1, and the status read shows full=1. Write addr3=1 -> overflow=0.
REQ-022 Write addr2=1 with lcd_data_in=0x9341 -> rd_n low 4 cycles, oe=0 throughout, rd_valid=1. A read of addr0 returns 0x00009341 one cycle later, and rd_valid=0 afterwards.
REQ-023 Assert reset during STROBE of a write -> all LCD outputs go idle in the same cycle, level=0, and no transfer occurs after release.
REQ-024 Push while a pop occurs at level 8 -> the push is dropped (level 7). Push while a pop occurs at level 3 -> level stays 3.
